// File: rtl/i4001_rom_arbiter.sv
// i4001_rom_arbiter: round-robin, pipelined, tagged sharing of one ROM block RAM among NUM_REQ requesters
// Ports: sysclk/poc (sync active-high reset); req_valid/req_addr/req_ready per requester;
//   rsp_valid/rsp_data per requester; bram_en/bram_addr/bram_data to the block RAM.
// Optional ROM_ARB_PERF_EN adds wait_cnt[15:0] and max_wait[3:0] arbitration statistics.
module i4001_rom_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int BRAM_LATENCY = 1
) (
  input  logic                        sysclk,
  input  logic                        poc,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0]   rsp_data,
  output logic                        bram_en,
  output logic [ADDR_W-1:0]           bram_addr,
  input  logic [DATA_W-1:0]           bram_data
`ifdef ROM_ARB_PERF_EN
  ,
  output logic [15:0]                 wait_cnt,
  output logic [3:0]                  max_wait
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] pending_q, pending_d, inflight_q, inflight_d, elig, rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][ADDR_W-1:0] slot_q, slot_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [IW-1:0] rr_q, rr_d, gidx, j, ridx;
  logic gnt, ret, bram_en_q, bram_en_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  // Tag pipe: stage 0 is registered with bram_en, the last stage lines up with bram_data.
  logic [BRAM_LATENCY:0] pv_q, pv_d;
  logic [BRAM_LATENCY:0][IW-1:0] pi_q, pi_d;
  assign req_ready = ~pending_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign bram_en   = bram_en_q;
  assign bram_addr = bram_addr_q;
  assign ret       = pv_q[BRAM_LATENCY];
  assign ridx      = pi_q[BRAM_LATENCY];
  // Scan downward so the last hit, i.e. the closest to rr_q, wins.
  always_comb begin
    elig = pending_q & ~inflight_q;
    gnt  = 1'b0;
    gidx = '0;
    j    = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      j = IW'((int'(rr_q) + k) % NUM_REQ);
      if (elig[j]) begin
        gnt  = 1'b1;
        gidx = j;
      end
    end
    rr_d = gnt ? IW'((int'(gidx) + 1) % NUM_REQ) : rr_q;
  end
  always_comb begin
    pending_d   = pending_q;
    inflight_d  = inflight_q;
    slot_d      = slot_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        slot_d[i]    = req_addr[i*ADDR_W +: ADDR_W];
      end
    if (gnt) inflight_d[gidx] = 1'b1;
    if (ret) begin
      pending_d[ridx]   = 1'b0;
      inflight_d[ridx]  = 1'b0;
      rsp_valid_d[ridx] = 1'b1;
      rsp_data_d[ridx]  = bram_data;
    end
    bram_en_d   = gnt;
    bram_addr_d = gnt ? slot_q[gidx] : bram_addr_q;
    pv_d        = {pv_q[BRAM_LATENCY-1:0], gnt};
    pi_d        = {pi_q[BRAM_LATENCY-1:0], gidx};
  end
  always_ff @(posedge sysclk) begin
    if (poc) begin
      pending_q   <= '0;
      inflight_q  <= '0;
      slot_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rr_q        <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      pv_q        <= '0;
      pi_q        <= '0;
    end else begin
      pending_q   <= pending_d;
      inflight_q  <= inflight_d;
      slot_q      <= slot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rr_q        <= rr_d;
      bram_en_q   <= bram_en_d;
      bram_addr_q <= bram_addr_d;
      pv_q        <= pv_d;
      pi_q        <= pi_d;
    end
  end
`ifdef ROM_ARB_PERF_EN
  logic [NUM_REQ-1:0] waiting;
  logic [NUM_REQ-1:0][3:0] wt_q, wt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] max_wait_q, max_wait_d;
  assign wait_cnt = wait_cnt_q;
  assign max_wait = max_wait_q;
  // wt tracks how many cycles each eligible requester has been passed over.
  always_comb begin
    waiting = elig;
    if (gnt) waiting[gidx] = 1'b0;
    wait_cnt_d = (|waiting && wait_cnt_q != 16'hFFFF) ? wait_cnt_q + 16'd1 : wait_cnt_q;
    for (int i = 0; i < NUM_REQ; i++)
      wt_d[i] = waiting[i] ? ((wt_q[i] == 4'hF) ? wt_q[i] : wt_q[i] + 4'd1) : 4'h0;
    max_wait_d = (gnt && wt_q[gidx] > max_wait_q) ? wt_q[gidx] : max_wait_q;
  end
  always_ff @(posedge sysclk) begin
    if (poc) begin
      wt_q       <= '0;
      wait_cnt_q <= '0;
      max_wait_q <= '0;
    end else begin
      wt_q       <= wt_d;
      wait_cnt_q <= wait_cnt_d;
      max_wait_q <= max_wait_d;
    end
  end
`endif
endmodule

// File: tb/tb_i4001_rom_arbiter.sv
// tb_i4001_rom_arbiter: directed and random checks of i4001_rom_arbiter against a cycle-level reference model
module tb_i4001_rom_arbiter;
  localparam int N = 4;
  localparam int LAT = 1;
  logic sysclk, poc;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N*12-1:0] req_addr;
  logic [N*8-1:0] rsp_data;
  logic bram_en;
  logic [11:0] bram_addr;
  logic [7:0] bram_data;
`ifdef ROM_ARB_PERF_EN
  logic [15:0] wait_cnt;
  logic [3:0] max_wait;
`endif
  i4001_rom_arbiter #(.NUM_REQ(N), .ADDR_W(12), .DATA_W(8), .BRAM_LATENCY(LAT)) dut (
    .sysclk(sysclk), .poc(poc), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_data(bram_data)
`ifdef ROM_ARB_PERF_EN
    , .wait_cnt(wait_cnt), .max_wait(max_wait)
`endif
  );
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;
  logic [7:0] rom [4096];
  logic [7:0] dl [LAT];
  always @(posedge sysclk) begin
    if (bram_en === 1'b1) dl[0] <= rom[bram_addr];
    for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
  end
  assign bram_data = dl[LAT-1];
  int checks = 0, errors = 0, cyc = 0;
  bit m_pend[N], m_infl[N];
  logic [11:0] m_addr[N];
  int m_due[N];
  int m_rr;
  logic [7:0] m_rd[N];
  logic [N-1:0] m_rv;
  bit m_en;
  logic [11:0] m_ba;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // Model: pending/in-flight flags, a due cycle per outstanding read, round-robin pointer.
  task automatic tick();
    @(posedge sysclk);
    cyc++;
    m_rv = '0;
    if (poc) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_infl[i] = 0; m_due[i] = -1; m_rd[i] = 8'h00;
      end
      m_rr = 0; m_en = 0; m_ba = 12'h000;
    end else begin
      int g;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_rr + k) % N] && !m_infl[(m_rr + k) % N]) g = (m_rr + k) % N;
      m_en = (g >= 0);
      if (g >= 0) begin
        m_ba = m_addr[g]; m_infl[g] = 1; m_due[g] = cyc + 1 + LAT; m_rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && !m_pend[i]) begin
          m_pend[i] = 1; m_addr[i] = req_addr[i*12 +: 12];
        end
      for (int i = 0; i < N; i++)
        if (m_due[i] == cyc) begin
          m_rv[i] = 1'b1; m_rd[i] = rom[m_addr[i]]; m_pend[i] = 0; m_infl[i] = 0; m_due[i] = -1;
        end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("ready%0d@%0d", i, cyc), 32'(req_ready[i]), 32'(!m_pend[i]));
      check($sformatf("rsp_valid%0d@%0d", i, cyc), 32'(rsp_valid[i]), 32'(m_rv[i]));
      check($sformatf("rsp_data%0d@%0d", i, cyc), 32'(rsp_data[i*8 +: 8]), 32'(m_rd[i]));
    end
    check($sformatf("bram_en@%0d", cyc), 32'(bram_en), 32'(m_en));
    check($sformatf("bram_addr@%0d", cyc), 32'(bram_addr), 32'(m_ba));
  endtask
  task automatic do_reset();
    req_valid = '0;
    poc = 1'b1;
    tick();
    poc = 1'b0;
  endtask
  initial begin
    int grants, t_rdy, t_en2, n_en, t;
    bit found, prev_rdy;
    logic [11:0] seq [4];
    for (int a = 0; a < 4096; a++) rom[a] = 8'($urandom);
    rom[12'h012] = 8'hA5;
    for (int k = 0; k < LAT; k++) dl[k] = 8'h00;
    req_addr = '0;
    do_reset();
    check("reset_ready", 32'(req_ready), 32'hF);
    check("reset_rsp_data", rsp_data, 32'h0);
    // single request, 3-cycle latency
    req_valid = 4'b0001; req_addr[11:0] = 12'h012;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_data", 32'(rsp_data[7:0]), 32'hA5);
    tick();
    check("t1_pulse_one_cycle", 32'(rsp_valid), 32'h0);
    // all four simultaneous
    do_reset();
    req_valid = 4'hF; req_addr = {12'h300, 12'h200, 12'h100, 12'h000};
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seq[k] = bram_addr;
    end
    check("t2_addr0", 32'(seq[0]), 32'h000);
    check("t2_addr1", 32'(seq[1]), 32'h100);
    check("t2_addr2", 32'(seq[2]), 32'h200);
    check("t2_addr3", 32'(seq[3]), 32'h300);
    // fairness: req0 always re-posting, req2 posts once
    do_reset();
    req_valid = 4'b0001; req_addr = '0; req_addr[11:0] = 12'h0AB; req_addr[35:24] = 12'h2AB;
    for (int k = 0; k < 5; k++) tick();
    req_valid = 4'b0101;
    tick();
    req_valid = 4'b0001;
    grants = 0; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (bram_en) begin
        grants++;
        if (bram_addr == 12'h2AB) found = 1;
      end
    end
    check("t3_req2_granted", 32'(found), 32'h1);
    check("t3_grants_le4", 32'(grants <= 4), 32'h1);
    // back-to-back: second bram_en lands the cycle after the re-post edge
    do_reset();
    req_valid = 4'b0010; req_addr = '0; req_addr[23:12] = 12'h1CD;
    t_rdy = -1; t_en2 = -1; n_en = 0; prev_rdy = 1; t = 0;
    for (int k = 0; k < 20 && t_en2 < 0; k++) begin
      tick();
      t++;
      if (!prev_rdy && req_ready[1] && t_rdy < 0) t_rdy = t;
      prev_rdy = req_ready[1];
      if (bram_en) begin
        n_en++;
        if (n_en == 2) t_en2 = t;
      end
    end
    check("t4_second_en_found", 32'(t_en2 > 0 && t_rdy > 0), 32'h1);
    check("t4_en_after_ready", 32'(t_en2 - t_rdy), 32'd2);
    req_valid = '0;
    // reset one cycle after grant
    do_reset();
    req_valid = 4'b1000; req_addr = '0; req_addr[47:36] = 12'h3EE;
    tick();
    req_valid = '0;
    tick();
    check("t5_granted", 32'(bram_en), 32'h1);
    poc = 1'b1;
    tick();
    poc = 1'b0;
    found = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rsp_valid != 0) found = 1;
    end
    check("t5_no_rsp", 32'(found), 32'h0);
    check("t5_ready", 32'(req_ready), 32'hF);
    check("t5_data", rsp_data, 32'h0);
`ifdef ROM_ARB_PERF_EN
    do_reset();
    req_valid = 4'hF; req_addr = {12'h300, 12'h200, 12'h100, 12'h000};
    tick();
    req_valid = '0;
    for (int k = 0; k < 6; k++) tick();
    check("t6_wait_cnt", 32'(wait_cnt), 32'd3);
    check("t6_max_wait", 32'(max_wait), 32'd3);
`endif
    // random traffic, changing addresses, occasional reset
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom);
      req_addr = 48'({$urandom, $urandom});
      poc = ($urandom_range(63) == 0);
      tick();
    end
    poc = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 8; k++) tick();
    check("drain_ready", 32'(req_ready), 32'hF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
